// File: rtl/ahb_mem_write_buffer.sv
// Posted-write buffer between the AHB slave stage and an SRAM port.
// Queues {addr, data} beats in a DEPTH-entry FIFO and drains them through a req/ack handshake.
module ahb_mem_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] mem_WR_addr,
   input  logic        mem_write_flag,
   input  logic [31:0] HWDATA_toMem,
   output logic        HREADY,
   output logic        sram_req,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic        sram_ack,
   output logic [15:0] wr_count,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);
   localparam logic [CW-1:0] HR_LIMIT  = CW'(DEPTH - 2);
   localparam logic [CW-1:0] ONE       = CW'(1);

   typedef enum logic {IDLE, REQ} state_t;

   // Handshake: a beat transfers on any edge where sram_req and sram_ack are both high;
   // sram_req, sram_addr and sram_wdata stay stable until that edge.
   state_t         state_q, state_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [15:0]    wr_count_q, wr_count_d;
   logic           overflow_q, overflow_d;
   logic [63:0]    mem_q [DEPTH];
   logic [63:0]    mem_d [DEPTH];

   logic           pop;
   logic           push;
   logic [63:0]    head;

   assign head = mem_q[rd_ptr_q];
   assign pop  = (state_q == REQ) && sram_ack;
   // A full FIFO still accepts a beat when the head leaves on the same edge.
   assign push = mem_write_flag && ((count_q < FULL) || pop);

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wr_count_d = wr_count_q;
      overflow_d = overflow_q;
      state_d    = state_q;

      if (push) begin
         mem_d[wr_ptr_q] = {mem_WR_addr, HWDATA_toMem};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         wr_count_d = wr_count_q + 16'd1;
      end
      if (push && !pop) begin
         count_d = count_q + ONE;
      end else if (pop && !push) begin
         count_d = count_q - ONE;
      end
      if (mem_write_flag && !push) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (sram_ack && (count_q == ONE) && !push) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_count_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wr_count_q <= wr_count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: entries are only visible through count and the pointers.
   always_ff @(posedge HCLK) begin
      mem_q <= mem_d;
   end

   assign HREADY     = (count_q <= HR_LIMIT);
   assign sram_req   = (state_q == REQ);
   assign sram_addr  = sram_req ? {head[63:34], 2'b00} : 32'h0;
   assign sram_wdata = sram_req ? head[31:0] : 32'h0;
   assign wr_count   = wr_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_ahb_mem_write_buffer.sv
// Directed bench for ahb_mem_write_buffer: latency, back-pressure, overflow,
// simultaneous push/pop, mid-transfer reset and wr_count wrap.
module tb_ahb_mem_write_buffer;

   localparam int DEPTH = 4;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] mem_WR_addr;
   logic        mem_write_flag;
   logic [31:0] HWDATA_toMem;
   logic        HREADY;
   logic        sram_req;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        sram_ack;
   logic [15:0] wr_count;
   logic        overflow;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [63:0] exp_q[$];

   ahb_mem_write_buffer #(.DEPTH(DEPTH)) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .mem_WR_addr    (mem_WR_addr),
      .mem_write_flag (mem_write_flag),
      .HWDATA_toMem   (HWDATA_toMem),
      .HREADY         (HREADY),
      .sram_req       (sram_req),
      .sram_addr      (sram_addr),
      .sram_wdata     (sram_wdata),
      .sram_ack       (sram_ack),
      .wr_count       (wr_count),
      .overflow       (overflow)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic push_entry(input logic [31:0] a, input logic [31:0] d);
      mem_write_flag = 1'b1;
      mem_WR_addr    = a;
      HWDATA_toMem   = d;
      exp_q.push_back({a, d});
      tick();
      mem_write_flag = 1'b0;
   endtask

   task automatic check_head(input string tag);
      logic [63:0] e;
      e = exp_q.pop_front();
      check({tag, "_req"},  32'(sram_req), 32'd1);
      check({tag, "_addr"}, sram_addr, {e[63:34], 2'b00});
      check({tag, "_data"}, sram_wdata, e[31:0]);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (sram_req && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'(sram_req), 32'd0);
   endtask

   initial begin
      HRESET = 1'b1; mem_write_flag = 1'b0; sram_ack = 1'b0;
      mem_WR_addr = '0; HWDATA_toMem = '0;
      tick();
      tick();
      check("rst_req",      32'(sram_req), 32'd0);
      check("rst_hready",   32'(HREADY),   32'd1);
      check("rst_addr",     sram_addr,     32'd0);
      check("rst_wdata",    sram_wdata,    32'd0);
      check("rst_wr_count", 32'(wr_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      HRESET = 1'b0;

      // single write, ack tied high
      sram_ack = 1'b1;
      mem_write_flag = 1'b1; mem_WR_addr = 32'h0000_1003; HWDATA_toMem = 32'hDEAD_BEEF;
      tick();
      mem_write_flag = 1'b0;
      check("single_c1_req", 32'(sram_req), 32'd0);
      tick();
      check("single_c2_req",   32'(sram_req), 32'd1);
      check("single_c2_addr",  sram_addr,     32'h0000_1000);
      check("single_c2_wdata", sram_wdata,    32'hDEAD_BEEF);
      tick();
      check("single_c3_req",   32'(sram_req), 32'd0);
      check("single_wr_count", 32'(wr_count), 32'd1);

      // ack with nothing requested must be ignored
      repeat (3) tick();
      check("stray_ack_wr_count", 32'(wr_count), 32'd1);
      check("stray_ack_req",      32'(sram_req), 32'd0);

      // back-pressure: fill with ack low
      sram_ack = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         push_entry(32'h0000_2001 + 32'(i) * 4, 32'hA000_0000 + 32'(i));
         check("bp_count",  32'(dut.count_q), 32'(i + 1));
         check("bp_hready", 32'(HREADY), (i + 1 <= DEPTH - 2) ? 32'd1 : 32'd0);
      end
      check("bp_overflow", 32'(overflow), 32'd0);
      check("bp_req",      32'(sram_req), 32'd1);
      repeat (2) tick();
      check("bp_hold_addr",  sram_addr,  32'h0000_2000);
      check("bp_hold_wdata", sram_wdata, 32'hA000_0000);

      // fifth write is dropped
      mem_write_flag = 1'b1; mem_WR_addr = 32'h0000_3000; HWDATA_toMem = 32'h5555_5555;
      tick();
      mem_write_flag = 1'b0;
      check("ovf_flag",  32'(overflow),      32'd1);
      check("ovf_count", 32'(dut.count_q),   32'd4);

      // release ack: four back-to-back pops in push order
      sram_ack = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         check_head("drain_bp");
         tick();
      end
      check("drain_bp_done_req",  32'(sram_req), 32'd0);
      check("drain_bp_wr_count",  32'(wr_count), 32'd5);
      check("drain_bp_sticky",    32'(overflow), 32'd1);
      repeat (2) tick();
      check("drain_bp_no_extra",  32'(wr_count), 32'd5);

      // simultaneous push and pop at full
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      check("rst2_overflow", 32'(overflow), 32'd0);
      sram_ack = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         push_entry(32'h0000_5000 + 32'(i) * 4, 32'hB000_0000 + 32'(i));
      end
      check("pp_full_count", 32'(dut.count_q), 32'd4);
      mem_write_flag = 1'b1; mem_WR_addr = 32'h0000_5013; HWDATA_toMem = 32'hB000_0004;
      exp_q.push_back({32'h0000_5013, 32'hB000_0004});
      sram_ack = 1'b1;
      check_head("pp_first");
      tick();
      mem_write_flag = 1'b0;
      check("pp_count",    32'(dut.count_q), 32'd4);
      check("pp_overflow", 32'(overflow),    32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         check_head("pp_drain");
         tick();
      end
      check("pp_done_req",  32'(sram_req), 32'd0);
      check("pp_wr_count",  32'(wr_count), 32'd5);

      // reset mid-transfer with three entries queued
      sram_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push_entry(32'h0000_6000 + 32'(i) * 4, 32'hC000_0000 + 32'(i));
      end
      check("midrst_pre_req", 32'(sram_req), 32'd1);
      HRESET = 1'b1; sram_ack = 1'b1;
      mem_write_flag = 1'b1; mem_WR_addr = 32'h0000_7000; HWDATA_toMem = 32'h7777_7777;
      tick();
      HRESET = 1'b0; mem_write_flag = 1'b0;
      exp_q.delete();
      check("midrst_req",      32'(sram_req),      32'd0);
      check("midrst_hready",   32'(HREADY),        32'd1);
      check("midrst_wr_count", 32'(wr_count),      32'd0);
      check("midrst_count",    32'(dut.count_q),   32'd0);
      repeat (4) tick();
      check("midrst_after_req",      32'(sram_req), 32'd0);
      check("midrst_after_wr_count", 32'(wr_count), 32'd0);

      // wr_count wrap: 65535 streamed writes, then one more
      sram_ack = 1'b1;
      mem_write_flag = 1'b1; mem_WR_addr = 32'h0000_4000;
      for (int i = 0; i < 65535; i++) begin
         HWDATA_toMem = 32'(i);
         tick();
      end
      mem_write_flag = 1'b0;
      wait_idle("stream");
      check("wrap_pre", 32'(wr_count), 32'h0000_FFFF);
      mem_write_flag = 1'b1; mem_WR_addr = 32'h0000_4004; HWDATA_toMem = 32'h0000_0001;
      tick();
      mem_write_flag = 1'b0;
      tick();
      check("wrap_req",  32'(sram_req), 32'd1);
      tick();
      check("wrap_done", 32'(sram_req), 32'd0);
      check("wrap_post", 32'(wr_count), 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
